rand_word_arbiter: RTL and testbench
====================================

// Module: rand_word_arbiter
// PURPOSE
//  Shares the single 2-bit randomizer between NUM_REQ requesters. Runs a post-reset
//  warm-up, then grants round-robin. For each grant it enables the randomizer for
//  WORD_W/RAND_W cycles and shifts its output into a WORD_W-bit word. The word is
//  delivered to the granted requester over a valid/ready handshake.
//  Sits between the user-logic requesters and the randomizer instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  RAND_W   2   width of randomizer output o_r
//  WORD_W   8   delivered word width; must be an integer multiple of RAND_W
//  WARMUP   16  randomizer-enabled cycles discarded after reset (>=1)
// PORTS
//  i_clk      in   1        clock, rising edge
//  i_reset    in   1        asynchronous, active-high reset
//  i_req      in   NUM_REQ  per-requester request; held high until served
//  o_rng_en   out  1        drives randomizer i_en
//  i_rng_r    in   RAND_W   randomizer o_r
//  o_gnt      out  NUM_REQ  one-hot grant; all-zero when no grant is active
//  o_word     out  WORD_W   random word; meaningful only while o_valid=1
//  o_valid    out  1        word ready for the requester in o_gnt
//  i_ready    in   1        requester accepts the word; handshake = o_valid & i_ready
//  o_busy     out  1        high in every state other than IDLE
// BEHAVIOUR
//  Reset values (async): state=WARMUP, o_rng_en=0, o_gnt=0, o_word=0, o_valid=0,
//   o_busy=1, rr_ptr=0, counters=0.
//  All outputs are registered. FILL_CYC = WORD_W/RAND_W.
//  FSM:
//   WARMUP: o_rng_en=1 for exactly WARMUP cycles; i_rng_r is ignored; then -> IDLE.
//    Requests raised during WARMUP wait.
//   IDLE: if |i_req, pick the first set bit searching upward from rr_ptr with
//    wrap-around. Register o_gnt one-hot, clear the fill counter, -> FILL.
//    With no request: stay in IDLE, o_rng_en=0.
//   FILL: o_rng_en=1. In each FILL cycle:
//    shift <= {shift[WORD_W-RAND_W-1:0], i_rng_r}   (first sample ends up in the MSBs).
//    After FILL_CYC samples: o_word <= shift, o_valid <= 1, o_rng_en <= 0, -> PRESENT.
//    Grant is locked during FILL; changes on i_req are ignored.
//   PRESENT: hold o_word, o_gnt, o_valid.
//    On o_valid & i_ready: o_valid=0, o_gnt=0, rr_ptr = grantee index + 1 (mod NUM_REQ),
//     -> IDLE.
//    If the grantee's i_req drops before the handshake: the word is discarded with the
//     same pointer update, -> IDLE. Dropping i_req takes priority over i_ready in the
//     same cycle.
//  Grant-to-valid latency: exactly FILL_CYC+1 clocks after o_gnt rises.
//  Back-to-back service: at least one IDLE cycle between handshake and the next grant.
//  Fairness: a continuously requesting requester is served within NUM_REQ grants.
//  Reset asserted mid-operation: the word in flight is lost and the block returns to
//   WARMUP.
//  Arithmetic widths:
//   rr_ptr    $clog2(NUM_REQ) bits; explicit wrap for non-power-of-2 NUM_REQ
//   fill_cnt  $clog2(FILL_CYC+1) bits
//   warm_cnt  $clog2(WARMUP+1) bits
// STRUCTURE
//  Shared package rand_pkg:
//   - state enum {WARMUP, IDLE, FILL, PRESENT}
//   - RAND_W constant
//   - function rr_pick(req, ptr) returning a one-hot grant
//  Sub-module rr_arbiter: combinational round-robin pick from i_req and rr_ptr,
//   producing one-hot and index. FSM, counters and shift register stay in the top.
//  Elaboration check: error if WORD_W % RAND_W != 0.
// TESTING
//  The bench drives i_rng_r from a stub that counts 0,1,2,3,... while o_rng_en=1.
//  Defaults are used unless stated.
//  1 Release reset, i_req=4'b0001 held -> o_rng_en=1 for 16 cycles; o_gnt=0001;
//    o_valid after 5 more clocks; o_word=8'h1B (stub restarted at 0 for FILL).
//  2 i_req=4'b1111 held, i_ready=1 -> grants 0001,0010,0100,1000,0001 in that order.
//  3 i_req=4'b1010 with rr_ptr=2 -> first grant 1000, then 0010.
//  4 i_ready=0 for 10 cycles in PRESENT -> o_word/o_gnt stable for all 10; single
//    handshake on i_ready=1.
//  5 Grantee drops i_req in PRESENT -> o_valid falls next cycle; next grant goes to
//    another requester; no handshake recorded.
//  6 Assert i_reset during FILL -> all outputs at reset values asynchronously; full
//    16-cycle WARMUP repeats.

Source files
------------

// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types, constants and round-robin pick for rand_word_arbiter
package rand_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FILL    = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  localparam int RAND_W  = 2;
  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input logic [IDX_W:0]     n);
    logic [MAX_REQ-1:0] g;
    logic [IDX_W:0]     idx;
    g = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + k[IDX_W:0];
      if (idx >= n) idx = idx - n;
      if ((k[IDX_W:0] < n) && req[idx[IDX_W-1:0]]) begin
        g = '0;
        g[idx[IDX_W-1:0]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rand_word_arbiter_if.sv
// rtl/rand_word_arbiter_if.sv - requester-side grant and word handshake bundle
interface rand_word_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WORD_W-1:0]  word;
  logic               valid;
  logic               ready;

  modport master (input req, input ready, output gnt, output word, output valid);
  modport slave  (output req, output ready, input gnt, input word, input valid);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick producing one-hot grant and index
module rr_arbiter
  import rand_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  localparam logic [IDX_W:0] N_REQ = (IDX_W + 1)'(NUM_REQ);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [IDX_W-1:0]   w_ptr_ext;
  logic [MAX_REQ-1:0] w_pick;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ must be in 2..MAX_REQ");
  end

  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_REQ-1:0]   = i_req;
    w_ptr_ext                = '0;
    w_ptr_ext[PTR_W-1:0]     = i_ptr;
    w_pick                   = rr_pick(w_req_ext, w_ptr_ext, N_REQ);
  end

  assign o_onehot = w_pick[NUM_REQ-1:0];
  assign o_any    = |w_pick;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_onehot[i]) o_idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/rand_word_arbiter.sv
// rtl/rand_word_arbiter.sv - shares one randomizer between requesters, assembling a word per grant
module rand_word_arbiter
  import rand_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int RAND_W  = rand_pkg::RAND_W,
  parameter int WORD_W  = 8,
  parameter int WARMUP  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_rng_en,
  input  logic [RAND_W-1:0]  i_rng_r,
  output logic               o_busy,
  rand_word_arbiter_if.master bus
);

  localparam int FILL_CYC = WORD_W / RAND_W;
  localparam int FILL_W   = $clog2(FILL_CYC + 1);
  localparam int WARM_W   = $clog2(WARMUP + 1);
  localparam int PTR_W    = $clog2(NUM_REQ);

  if ((WORD_W % RAND_W) != 0) begin : g_bad_word_w
    $error("rand_word_arbiter: WORD_W must be a multiple of RAND_W");
  end
  if (WARMUP < 1) begin : g_bad_warmup
    $error("rand_word_arbiter: WARMUP must be at least 1");
  end

  state_t               r_state, w_state_n;
  logic [WARM_W-1:0]    r_warm_cnt, w_warm_cnt_n;
  logic [FILL_W-1:0]    r_fill_cnt, w_fill_cnt_n;
  logic [PTR_W-1:0]     r_ptr, w_ptr_n;
  logic [PTR_W-1:0]     r_idx, w_idx_n;
  logic [WORD_W-1:0]    r_shift, w_shift_n;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_n;
  logic [WORD_W-1:0]    r_word, w_word_n;
  logic                 r_valid, w_valid_n;
  logic                 r_rng_en, w_rng_en_n;
  logic                 r_busy, w_busy_n;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [PTR_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_grantee_req;
  logic                 w_warm_done;
  logic                 w_fill_done;
  logic                 w_release;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_grantee_req = |(bus.req & r_gnt);
  assign w_warm_done   = (r_warm_cnt == WARM_W'(WARMUP));
  assign w_fill_done   = (r_fill_cnt == FILL_W'(FILL_CYC));
  // A withdrawn request releases the grant whether or not ready is also high.
  assign w_release     = !w_grantee_req || bus.ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_WARMUP;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_WARMUP:  if (w_warm_done) w_state_n = ST_IDLE;
      ST_IDLE:    if (w_pick_any)  w_state_n = ST_FILL;
      ST_FILL:    if (w_fill_done) w_state_n = ST_PRESENT;
      ST_PRESENT: if (w_release)   w_state_n = ST_IDLE;
      default:                     w_state_n = ST_WARMUP;
    endcase
  end

  always_comb begin
    w_warm_cnt_n = r_warm_cnt;
    w_fill_cnt_n = r_fill_cnt;
    w_ptr_n      = r_ptr;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;
    w_gnt_n      = r_gnt;
    w_word_n     = r_word;
    w_valid_n    = r_valid;
    w_rng_en_n   = 1'b0;
    w_busy_n     = (w_state_n != ST_IDLE);
    case (r_state)
      ST_WARMUP: begin
        if (!w_warm_done) begin
          w_warm_cnt_n = r_warm_cnt + 1'b1;
          w_rng_en_n   = 1'b1;
        end
      end
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_n      = w_pick_onehot;
          w_idx_n      = w_pick_idx;
          w_fill_cnt_n = '0;
          w_rng_en_n   = 1'b1;
        end
      end
      ST_FILL: begin
        if (w_fill_done) begin
          w_word_n  = r_shift;
          w_valid_n = 1'b1;
        end else begin
          // Truncating the concatenation drops the oldest sample's slot, so sample 0 lands in the MSBs.
          w_shift_n    = WORD_W'({r_shift, i_rng_r});
          w_fill_cnt_n = r_fill_cnt + 1'b1;
          w_rng_en_n   = (r_fill_cnt != FILL_W'(FILL_CYC - 1));
        end
      end
      ST_PRESENT: begin
        if (w_release) begin
          w_valid_n = 1'b0;
          w_gnt_n   = '0;
          w_ptr_n   = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_warm_cnt <= '0;
      r_fill_cnt <= '0;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_gnt      <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_rng_en   <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_warm_cnt <= w_warm_cnt_n;
      r_fill_cnt <= w_fill_cnt_n;
      r_ptr      <= w_ptr_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_gnt      <= w_gnt_n;
      r_word     <= w_word_n;
      r_valid    <= w_valid_n;
      r_rng_en   <= w_rng_en_n;
      r_busy     <= w_busy_n;
    end
  end

  assign o_rng_en  = r_rng_en;
  assign o_busy    = r_busy;
  assign bus.gnt   = r_gnt;
  assign bus.word  = r_word;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_rand_word_arbiter.sv
// tb/tb_rand_word_arbiter.sv - scoreboard bench for rand_word_arbiter with a counting randomizer stub
module tb_rand_word_arbiter;

  localparam int NUM_REQ = 4;
  localparam int RAND_W  = 2;
  localparam int WORD_W  = 8;
  localparam int WARMUP  = 16;
  localparam int FILL_CYC = WORD_W / RAND_W;
  localparam logic [7:0] STUB_WORD = {2'd0, 2'd1, 2'd2, 2'd3};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rng_en;
  logic [RAND_W-1:0] rng_r;
  logic              busy;
  logic [7:0]        stub_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int m_ptr    = 0;
  logic [3:0] exp_gnt_q[$];
  logic [7:0] exp_word_q[$];

  always #5 clk = ~clk;

  rand_word_arbiter_if #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) u_if ();

  rand_word_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RAND_W  (RAND_W),
    .WORD_W  (WORD_W),
    .WARMUP  (WARMUP)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .o_rng_en (rng_en),
    .i_rng_r  (rng_r),
    .o_busy   (busy),
    .bus      (u_if)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)         stub_cnt <= 8'd0;
    else if (rng_en) stub_cnt <= stub_cnt + 8'd1;
  end
  assign rng_r = stub_cnt[1:0];

  always @(posedge clk) begin
    if (!rst && u_if.valid && u_if.ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [3:0] model_pick(input logic [3:0] req, input int ptr);
    logic [3:0] g = 4'b0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (ptr + k) % NUM_REQ;
      if (req[j] && g == 4'b0000) g[j] = 1'b1;
    end
    return g;
  endfunction

  task automatic push_grant(input logic [3:0] req);
    logic [3:0] g;
    g = model_pick(req, m_ptr);
    exp_gnt_q.push_back(g);
    exp_word_q.push_back(STUB_WORD);
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) m_ptr = (i + 1) % NUM_REQ;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_one(output logic [3:0] g, output logic [7:0] w, output int lat, output bit ok);
    int n;
    ok = 1'b1; n = 0; lat = 0; g = '0; w = '0;
    while (u_if.gnt == 4'b0000 && n < 60) begin tick(); n++; end
    if (u_if.gnt == 4'b0000) begin ok = 1'b0; return; end
    g = u_if.gnt;
    while (!u_if.valid && lat < 20) begin tick(); lat++; end
    if (!u_if.valid) ok = 1'b0;
    w = u_if.word;
  endtask

  task automatic count_warmup(output int en_cyc);
    int n;
    en_cyc = 0; n = 0;
    while (u_if.gnt == 4'b0000 && n < 60) begin
      tick(); n++;
      if (rng_en && u_if.gnt == 4'b0000) en_cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; u_if.req = '0; u_if.ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_ptr = 0;
    exp_gnt_q.delete();
    exp_word_q.delete();
  endtask

  task automatic test_reset();
    u_if.req = '0; u_if.ready = 1'b0;
    tick();
    n_checks++; if (rng_en !== 1'b0)        begin n_fail++; $display("FAIL reset_rng_en got %0b want 0", rng_en); end
    n_checks++; if (u_if.gnt !== 4'b0000)   begin n_fail++; $display("FAIL reset_gnt got %b want 0000", u_if.gnt); end
    n_checks++; if (u_if.word !== 8'h00)    begin n_fail++; $display("FAIL reset_word got %h want 00", u_if.word); end
    n_checks++; if (u_if.valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %0b want 0", u_if.valid); end
    n_checks++; if (busy !== 1'b1)          begin n_fail++; $display("FAIL reset_busy got %0b want 1", busy); end
  endtask

  task automatic test_warmup();
    int en_cyc, lat; logic [3:0] g, eg; logic [7:0] w, ew; bit ok;
    rst = 1'b0; m_ptr = 0;
    u_if.req = 4'b0001;
    push_grant(4'b0001);
    count_warmup(en_cyc);
    n_checks++; if (en_cyc != WARMUP) begin n_fail++; $display("FAIL warmup_en_cycles got %0d want %0d", en_cyc, WARMUP); end
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok)              begin n_fail++; $display("FAIL warmup_serve_timeout"); end
    n_checks++; if (g !== eg)         begin n_fail++; $display("FAIL warmup_gnt got %b want %b", g, eg); end
    n_checks++; if (lat != FILL_CYC+1) begin n_fail++; $display("FAIL warmup_latency got %0d want %0d", lat, FILL_CYC+1); end
    n_checks++; if (w !== ew)         begin n_fail++; $display("FAIL warmup_word got %h want %h", w, ew); end
    u_if.ready = 1'b1;
    tick();
    u_if.req = '0; u_if.ready = 1'b0;
    n_checks++; if (u_if.valid !== 1'b0 || u_if.gnt !== 4'b0000) begin
      n_fail++; $display("FAIL warmup_handshake valid=%0b gnt=%b want 0/0000", u_if.valid, u_if.gnt);
    end
  endtask

  task automatic test_round_robin();
    int lat; logic [3:0] g, eg; logic [7:0] w, ew; bit ok;
    do_reset();
    u_if.req = 4'b1111; u_if.ready = 1'b1;
    for (int i = 0; i < 5; i++) push_grant(4'b1111);
    for (int i = 0; i < 5; i++) begin
      serve_one(g, w, lat, ok);
      eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
      n_checks++; if (!ok || g !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b ok=%0b", i, g, eg, ok); end
      n_checks++; if (w !== ew)        begin n_fail++; $display("FAIL rr_word[%0d] got %h want %h", i, w, ew); end
      n_checks++; if (lat != FILL_CYC+1) begin n_fail++; $display("FAIL rr_latency[%0d] got %0d want %0d", i, lat, FILL_CYC+1); end
      tick();
      if (i == 4) u_if.req = '0;
      n_checks++; if (u_if.valid !== 1'b0 || u_if.gnt !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle_gap[%0d] valid=%0b gnt=%b busy=%0b want 0/0000/0", i, u_if.valid, u_if.gnt, busy);
      end
    end
    u_if.ready = 1'b0;
  endtask

  task automatic test_ptr_wrap();
    int lat; logic [3:0] g, eg; logic [7:0] w, ew; bit ok;
    u_if.ready = 1'b1;
    push_grant(4'b0010);
    u_if.req = 4'b0010;
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok || g !== eg) begin n_fail++; $display("FAIL wrap_setup_gnt got %b want %b", g, eg); end
    tick();
    push_grant(4'b1010); push_grant(4'b1010);
    u_if.req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      serve_one(g, w, lat, ok);
      eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
      n_checks++; if (!ok || g !== eg) begin n_fail++; $display("FAIL wrap_gnt[%0d] got %b want %b ok=%0b", i, g, eg, ok); end
      n_checks++; if (w !== ew)        begin n_fail++; $display("FAIL wrap_word[%0d] got %h want %h", i, w, ew); end
      tick();
      u_if.req = (i == 0) ? 4'b0010 : 4'b0000;
    end
    u_if.ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat, hs0; logic [3:0] g, eg; logic [7:0] w, ew; bit ok, stable;
    push_grant(4'b0100);
    u_if.req = 4'b0100; u_if.ready = 1'b0;
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok || g !== eg || w !== ew) begin n_fail++; $display("FAIL stall_serve gnt=%b word=%h want %b/%h", g, w, eg, ew); end
    hs0 = hs_cnt; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.word !== ew || u_if.gnt !== eg || u_if.valid !== 1'b1) stable = 1'b0;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL stall_hold word=%h gnt=%b valid=%0b want %h/%b/1", u_if.word, u_if.gnt, u_if.valid, ew, eg); end
    u_if.ready = 1'b1;
    tick();
    u_if.req = '0; u_if.ready = 1'b0;
    n_checks++; if (u_if.valid !== 1'b0) begin n_fail++; $display("FAIL stall_release valid got %0b want 0", u_if.valid); end
    tick(); tick();
    n_checks++; if (hs_cnt != hs0 + 1) begin n_fail++; $display("FAIL stall_handshakes got %0d want 1", hs_cnt - hs0); end
  endtask

  task automatic test_drop();
    int lat, hs0; logic [3:0] g, eg; logic [7:0] w, ew; bit ok;
    push_grant(4'b1001);
    u_if.req = 4'b1001; u_if.ready = 1'b0;
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok || g !== eg) begin n_fail++; $display("FAIL drop_first_gnt got %b want %b", g, eg); end
    hs0 = hs_cnt;
    u_if.req = 4'b0001;
    push_grant(4'b0001);
    tick();
    n_checks++; if (u_if.valid !== 1'b0 || u_if.gnt !== 4'b0000) begin
      n_fail++; $display("FAIL drop_discard valid=%0b gnt=%b want 0/0000", u_if.valid, u_if.gnt);
    end
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok || g !== eg) begin n_fail++; $display("FAIL drop_next_gnt got %b want %b", g, eg); end
    n_checks++; if (w !== ew)        begin n_fail++; $display("FAIL drop_next_word got %h want %h", w, ew); end
    u_if.ready = 1'b1;
    tick();
    u_if.req = '0; u_if.ready = 1'b0;
    tick();
    n_checks++; if (hs_cnt != hs0 + 1) begin n_fail++; $display("FAIL drop_handshakes got %0d want 1", hs_cnt - hs0); end
  endtask

  task automatic test_reset_mid_fill();
    int n, en_cyc, lat; logic [3:0] g, eg; logic [7:0] w, ew; bit ok;
    u_if.req = 4'b0010; n = 0;
    while (u_if.gnt == 4'b0000 && n < 20) begin tick(); n++; end
    n_checks++; if (u_if.gnt !== 4'b0010) begin n_fail++; $display("FAIL midfill_pre_gnt got %b want 0010", u_if.gnt); end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rng_en !== 1'b0)      begin n_fail++; $display("FAIL midfill_rng_en got %0b want 0", rng_en); end
    n_checks++; if (u_if.gnt !== 4'b0000) begin n_fail++; $display("FAIL midfill_gnt got %b want 0000", u_if.gnt); end
    n_checks++; if (u_if.word !== 8'h00)  begin n_fail++; $display("FAIL midfill_word got %h want 00", u_if.word); end
    n_checks++; if (u_if.valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL midfill_valid_busy got %0b/%0b want 0/1", u_if.valid, busy); end
    tick();
    rst = 1'b0; m_ptr = 0;
    exp_gnt_q.delete(); exp_word_q.delete();
    push_grant(4'b0010);
    count_warmup(en_cyc);
    n_checks++; if (en_cyc != WARMUP) begin n_fail++; $display("FAIL midfill_warmup got %0d want %0d", en_cyc, WARMUP); end
    serve_one(g, w, lat, ok);
    eg = exp_gnt_q.pop_front(); ew = exp_word_q.pop_front();
    n_checks++; if (!ok || g !== eg || lat != FILL_CYC+1) begin n_fail++; $display("FAIL midfill_regrant gnt=%b lat=%0d want %b/%0d", g, lat, eg, FILL_CYC+1); end
    n_checks++; if (w !== ew) begin n_fail++; $display("FAIL midfill_word_after got %h want %h", w, ew); end
    u_if.ready = 1'b1;
    tick();
    u_if.req = '0; u_if.ready = 1'b0;
  endtask

  initial begin
    u_if.req = '0;
    u_if.ready = 1'b0;
    test_reset();
    test_warmup();
    test_round_robin();
    test_ptr_wrap();
    test_stall();
    test_drop();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
